// File: rtl/dsp_mac_pipe_if.sv
// Operand/control and result bundle of the dsp_mac_pipe multiply-accumulate pipeline.
// The master drives operands and enable; the slave is the pipeline itself.
interface dsp_mac_pipe_if #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 40
);
  logic                 EN;
  logic                 IN_VALID;
  logic [A_WIDTH-1:0]   A;
  logic [B_WIDTH-1:0]   B;
  logic [ACC_WIDTH-1:0] C;
  logic [1:0]           MODE;
  logic                 ACC_CLR;
  logic [ACC_WIDTH-1:0] P;
  logic                 OUT_VALID;
  logic                 OVF;

  modport master (output EN, IN_VALID, A, B, C, MODE, ACC_CLR, input  P, OUT_VALID, OVF);
  modport slave  (input  EN, IN_VALID, A, B, C, MODE, ACC_CLR, output P, OUT_VALID, OVF);
endinterface

// File: rtl/dsp_mac_pipe.sv
// Multiply / multiply-add / accumulate pipeline: optional input and product registers,
// then a post-adder feeding the P register, with optional saturation and an overflow flag.
module dsp_mac_pipe #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 40,
  parameter bit SIGNED    = 1'b1,
  parameter bit REG_IN    = 1'b1,
  parameter bit REG_MULT  = 1'b1,
  parameter bit SATURATE  = 1'b0
) (
  input logic           CLK,
  input logic           ARST_N,
  dsp_mac_pipe_if.slave bus
);
  localparam int PW = A_WIDTH + B_WIDTH;

  typedef enum logic [1:0] {
    MODE_MUL  = 2'b00,
    MODE_MADD = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Control travels with its operands so it meets the matching product at the adder.
  typedef struct packed {
    logic                 valid;
    mode_e                mode;
    logic                 clr;
    logic [ACC_WIDTH-1:0] c;
  } ctl_t;

  ctl_t in_ctl;
  assign in_ctl = '{valid: bus.IN_VALID, mode: mode_e'(bus.MODE), clr: bus.ACC_CLR, c: bus.C};

  ctl_t               s1_ctl;
  logic [A_WIDTH-1:0] s1_a;
  logic [B_WIDTH-1:0] s1_b;

  if (REG_IN) begin : g_in_reg
    ctl_t               ctl_q;
    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    // NOTE: datapath registers are reset too, so a reset throws away any item in flight.
    always_ff @(posedge CLK or negedge ARST_N) begin
      if (!ARST_N) begin
        ctl_q <= '0;
        a_q   <= '0;
        b_q   <= '0;
      end else if (bus.EN) begin
        ctl_q <= in_ctl;
        a_q   <= bus.A;
        b_q   <= bus.B;
      end
    end
    assign s1_ctl = ctl_q;
    assign s1_a   = a_q;
    assign s1_b   = b_q;
  end else begin : g_in_bypass
    assign s1_ctl = in_ctl;
    assign s1_a   = bus.A;
    assign s1_b   = bus.B;
  end

  // Extending both operands to the product width makes one multiplier serve both signednesses.
  logic [PW-1:0] a_x, b_x, prod;
  assign a_x  = {{B_WIDTH{SIGNED & s1_a[A_WIDTH-1]}}, s1_a};
  assign b_x  = {{A_WIDTH{SIGNED & s1_b[B_WIDTH-1]}}, s1_b};
  assign prod = a_x * b_x;

  ctl_t          s2_ctl;
  logic [PW-1:0] s2_prod;

  if (REG_MULT) begin : g_mult_reg
    ctl_t          ctl_q;
    logic [PW-1:0] prod_q;
    always_ff @(posedge CLK or negedge ARST_N) begin
      if (!ARST_N) begin
        ctl_q  <= '0;
        prod_q <= '0;
      end else if (bus.EN) begin
        ctl_q  <= s1_ctl;
        prod_q <= prod;
      end
    end
    assign s2_ctl  = ctl_q;
    assign s2_prod = prod_q;
  end else begin : g_mult_bypass
    assign s2_ctl  = s1_ctl;
    assign s2_prod = prod;
  end

  logic [ACC_WIDTH-1:0] prod_ext, x_op, p_d, p_q;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf_d, out_valid_q, ovf_q;

  if (SIGNED) begin : g_sext
    assign prod_ext = ACC_WIDTH'($signed(s2_prod));
  end else begin : g_zext
    assign prod_ext = ACC_WIDTH'(s2_prod);
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    x_op = '0;
    case (s2_ctl.mode)
      MODE_MADD, MODE_LOAD: x_op = s2_ctl.c;
      MODE_ACC:             x_op = s2_ctl.clr ? '0 : p_q;
      default:              x_op = '0;
    endcase
    // One extra bit holds the true sign (signed) or the carry (unsigned).
    sum   = {SIGNED & prod_ext[ACC_WIDTH-1], prod_ext} + {SIGNED & x_op[ACC_WIDTH-1], x_op};
    ovf_d = SIGNED ? (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]) : sum[ACC_WIDTH];
    p_d   = sum[ACC_WIDTH-1:0];
    if (ovf_d && SATURATE) begin
      if (!SIGNED)             p_d = '1;
      else if (sum[ACC_WIDTH]) p_d = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else                     p_d = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  // P is also the accumulator feedback; bubbles leave it untouched.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (bus.EN) begin
      out_valid_q <= s2_ctl.valid;
      ovf_q       <= s2_ctl.valid & ovf_d;
      if (s2_ctl.valid) p_q <= p_d;
    end
  end

  assign bus.P         = p_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OVF       = ovf_q;
endmodule

// File: doc/dsp_mac_pipe.md
# dsp_mac_pipe

Parametrised multiply-accumulate pipeline for the z1010 DSP tile, the generalised successor to the fixed-configuration MAE mult/mult-add/macc variants. It covers all of those modes in one block, selected per operation: configurable operand widths, input and multiplier register stages, per-item mode control and an accumulator clear. It also adds a valid/enable pipeline and optional saturation with an overflow flag. Techmap targets it for inferred multiply, multiply-add and accumulate structures.

## Interface
- A_WIDTH, 18: width of operand A.
- B_WIDTH, 18: width of operand B.
- ACC_WIDTH, 40: width of C, P and the accumulator; must be ≥ A_WIDTH+B_WIDTH.
- SIGNED, 1: 1 = two's-complement operands and result; 0 = unsigned.
- REG_IN, 1: 1 = registered A/B/C/control input stage; 0 = bypass.
- REG_MULT, 1: 1 = register after the multiplier; 0 = bypass.
- SATURATE, 0: 1 = clamp on overflow; 0 = wrap.

Ports:
- CLK  in  1  clock, rising edge.
- ARST_N  in  1  asynchronous, active-low reset.
- EN  in  1  pipeline enable; 0 freezes every register in the block.
- IN_VALID  in  1  input item valid.
- A  in  A_WIDTH  multiplicand.
- B  in  B_WIDTH  multiplier.
- C  in  ACC_WIDTH  addend / accumulator load value.
- MODE  in  2  00 = P←A·B; 01 = P←A·B+C; 10 = P←P+A·B; 11 = P←C+A·B (accumulator load).
- ACC_CLR  in  1  with MODE=10, the feedback operand is forced to 0 for this item.
- P  out  ACC_WIDTH  result / accumulator register.
- OUT_VALID  out  1  P updated by a valid item this cycle.
- OVF  out  1  overflow on the item reported by OUT_VALID.

## Operation
- Stages: optional input register (REG_IN), multiplier, optional product register (REG_MULT), then a post-adder with the P register, which is always present.
- MODE, C, ACC_CLR and the valid bit are delayed alongside A/B and stay aligned with their product at the adder.
- Product is A_WIDTH+B_WIDTH bits, extended to ACC_WIDTH: sign-extended if SIGNED, else zero-extended.
- Adder operand X by mode:
  - MODE 00: X = 0.
  - MODE 01: X = C.
  - MODE 10: X = P, or 0 if ACC_CLR.
  - MODE 11: X = C.
  - ACC_CLR is ignored outside MODE 10.
- Sum is computed at ACC_WIDTH+1 bits. Overflow occurs when:
  - signed: the result falls outside [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1];
  - unsigned: there is a carry out.
- On overflow:
  - SATURATE=1: P clamps to the signed max/min, or to all-ones when unsigned.
  - SATURATE=0: P takes the low ACC_WIDTH bits.
  - OVF=1 in both cases.
- Invalid item (valid bit 0) at the adder: P holds, OUT_VALID=0, OVF=0. Bubbles never disturb an accumulation.
- The feedback path is the P register itself, so back-to-back MODE 10 items accumulate every cycle with no hazard.
- After reset, MODE 10 without ACC_CLR accumulates from P=0.

## Timing
- Latency L = REG_IN + REG_MULT + 1 enabled cycles from an IN_VALID=1 sample to its OUT_VALID=1. With default parameters L = 3.
- Throughput is one item per enabled cycle; there is no backpressure output.
- EN=0 holds all stage registers, including P, OUT_VALID and OVF, and inputs are not sampled. Stalled cycles do not count toward L.
- ARST_N low asynchronously clears all stage registers, P, OUT_VALID and OVF to 0 and discards in-flight items. Release is synchronous to CLK.
- Reset asserted during EN=0 still clears everything.

## Test plan
- Defaults, SIGNED=1, MODE=00, A=3, B=−4, IN_VALID for 1 cycle at cycle 0 -> at cycle 3, P=0xFFFFFFFFF4 (−12) and OUT_VALID=1 for exactly one cycle; OVF=0.
- MODE=10 stream, B=1 throughout:
  - first item A=10 with ACC_CLR=1, then A=1,2,3,4 back-to-back -> P = 10, 11, 13, 16, 20 on consecutive cycles;
  - an IN_VALID=0 bubble inserted mid-stream -> P holds for that cycle and the sequence is otherwise unchanged.
- MODE=11, C=100, A=7, B=7 -> P=149; next MODE=10, A=1, B=1 -> P=150; then MODE=01, C=5, A=2, B=2 -> P=9 (accumulator not used).
- Overflow:
  - MODE=11 loads C=2^39−1 with A=0; then MODE=10, A=1, B=1;
  - SATURATE=1 -> P=2^39−1, OVF=1;
  - SATURATE=0 -> P=−2^39, OVF=1;
  - SIGNED=0, SATURATE=1, load C=2^40−1, add 1 -> P=2^40−1, OVF=1.
- Stall: three valid items in flight, EN=0 for 4 cycles -> P, OUT_VALID and OVF frozen; results emerge in order after EN=1, each after exactly L enabled cycles.
- Reset mid-operation: during a MODE 10 stream with P=20, pulse ARST_N low between clock edges -> P=0 and OUT_VALID=0 immediately, no in-flight result emerges; after release, MODE=10, A=2, B=3 -> P=6.
